// File: rtl/spi_mem_loader.sv
// spi_mem_loader
// Receives SPI mode-0 write frames (header byte + payload bytes) by oversampling
// sclk/mosi/cs_n in the clk domain, and writes each payload byte to the SNN
// parameter memory with a single-cycle strobe at consecutive, wrapping addresses.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   sclk       SPI clock (idle low), asynchronous
//   mosi       SPI data, MSB first, sampled on sclk rise
//   cs_n       SPI chip select, active low, asynchronous
//   mem_data   memory write data
//   mem_addr   memory write address
//   mem_we     one-clk memory write strobe
//   busy       frame in progress
//   frame_err  sticky error flag for the current/last frame
//   checksum   mod-256 sum of payload bytes written this frame
//
// Optional feature macro: LOADER_CHECKSUM_EN builds the checksum accumulator;
// without it checksum is tied to zero.
//
// state | meaning
// IDLE  | waiting for a cs_n fall; outputs hold
// HDR   | shifting in the header byte
// DATA  | shifting payload bytes, one memory write per byte
// DROP  | bad header; ignore the rest of the frame

module spi_mem_loader #(
    parameter int MEM_DEPTH = 125,
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_n,
    output logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              busy,
    output logic              frame_err,
    output logic [7:0]        checksum
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;

    state_t              state, state_next;
    logic [2:0]          sclk_sync, cs_sync;
    logic [1:0]          mosi_sync;
    logic [1:0]          settle_cnt;
    logic                armed;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_next;
    logic [DATA_W-2:0]   shift, shift_next;
    logic [ADDR_W-1:0]   ptr, ptr_next;
    logic [DATA_W-1:0]   data_next;
    logic [ADDR_W-1:0]   addr_next;
    logic                we_next, err_next;

    logic                sclk_rise, cs_fall, cs_rise, byte_done, hdr_ok;
    logic [DATA_W-1:0]   shift_full;
    logic [ADDR_W-1:0]   hdr_addr;

    assign sclk_rise  = sclk_sync[1] & ~sclk_sync[2];
    assign cs_rise    = cs_sync[1] & ~cs_sync[2];
    // The synchronizers reset to idle levels, so a cs_n held low through reset
    // release would look like a fresh fall. Only accept falls once cs_n has been
    // seen high with fully flushed synchronizers.
    assign cs_fall    = armed & ~cs_sync[1] & cs_sync[2];
    assign shift_full = {shift, mosi_sync[1]};
    assign byte_done  = sclk_rise && (bit_cnt == CNT_W'(DATA_W - 1));
    assign hdr_addr   = shift_full[ADDR_W-1:0];
    assign hdr_ok     = shift_full[DATA_W-1] && (int'(hdr_addr) < MEM_DEPTH);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync  <= 3'b000;
            cs_sync    <= 3'b111;
            mosi_sync  <= 2'b00;
            settle_cnt <= 2'd3;
            armed      <= 1'b0;
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            ptr        <= '0;
            mem_data   <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[1:0], sclk};
            cs_sync    <= {cs_sync[1:0], cs_n};
            mosi_sync  <= {mosi_sync[0], mosi};
            if (settle_cnt != 2'd0) settle_cnt <= settle_cnt - 2'd1;
            armed      <= armed | ((settle_cnt == 2'd0) & cs_sync[1] & cs_sync[2]);
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            shift      <= shift_next;
            ptr        <= ptr_next;
            mem_data   <= data_next;
            mem_addr   <= addr_next;
            mem_we     <= we_next;
            frame_err  <= err_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        ptr_next     = ptr;
        data_next    = mem_data;
        addr_next    = mem_addr;
        we_next      = 1'b0;
        err_next     = frame_err;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next   = HDR;
                    bit_cnt_next = '0;
                    err_next     = 1'b0;
                end
            end
            HDR, DATA: begin
                if (sclk_rise) begin
                    shift_next   = shift_full[DATA_W-2:0];
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
                if (byte_done) begin
                    if (state == HDR) begin
                        if (hdr_ok) begin
                            ptr_next   = hdr_addr;
                            state_next = DATA;
                        end else begin
                            err_next   = 1'b1;
                            state_next = DROP;
                        end
                    end else begin
                        data_next = shift_full;
                        addr_next = ptr;
                        we_next   = 1'b1;
                        ptr_next  = (ptr == ADDR_W'(MEM_DEPTH - 1)) ? '0 : ptr + ADDR_W'(1);
                    end
                end
                // A byte completing in the same cycle as cs_n rising is kept;
                // only a genuinely partial byte flags an error.
                if (cs_rise) begin
                    state_next = IDLE;
                    if ((bit_cnt != '0) && !byte_done) err_next = 1'b1;
                end
            end
            DROP: begin
                if (cs_rise) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= 8'h00;
        end else if ((state == IDLE) && cs_fall) begin
            sum <= 8'h00;
        end else if (we_next) begin
            sum <= sum + 8'(data_next);
        end
    end

    assign checksum = sum;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: doc/spi_mem_loader.md
# spi_mem_loader

Serial configuration loader that sits directly upstream of the 125-byte parameter memory of the SNN core. It receives SPI mode-0 write frames from an external host, oversamples them in the system clock domain, and drives the memory write port (`data_in`, `addr`, `write_enable`) with one single-cycle write per received payload byte. Consecutive payload bytes go to consecutive addresses; the address wraps from the last location back to 0.

## Interface
- `MEM_DEPTH`, 125: number of addressable bytes; valid addresses are 0..MEM_DEPTH-1.
- `ADDR_W`, 7: address width.
- `DATA_W`, 8: data width; the header and all payload bytes are DATA_W bits.

- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `sclk`  in  1  SPI clock, asynchronous to clk, idle low (mode 0).
- `mosi`  in  1  SPI data, MSB first, sampled on sclk rising edge.
- `cs_n`  in  1  SPI chip select, active low, asynchronous.
- `mem_data`  out  DATA_W  write data to memory `data_in`.
- `mem_addr`  out  ADDR_W  write address to memory `addr`.
- `mem_we`  out  1  one-clk write strobe to memory `write_enable`.
- `busy`  out  1  high while a frame is in progress (state != IDLE).
- `frame_err`  out  1  sticky frame error flag for the current or last frame.
- `checksum`  out  8  modulo-256 sum of payload bytes written in the current frame (see Configuration).

## Operation
- `sclk`, `mosi` and `cs_n` each pass through a 2-FF synchronizer. A third register on `sclk`/`cs_n` supports edge detection. A sclk rise is sync2=1 and sync3=0. A cs_n fall is sync2=0 and sync3=1.
- Frame format: cs_n falls, then one header byte, then N≥0 payload bytes, then cs_n rises.
- Header: bit7 = 1 means write command; bits[6:0] give the start address.
- States:
  - IDLE: outputs hold. A cs_n fall moves to HDR, clears the bit counter, clears `frame_err` and clears `checksum`.
  - HDR: shifts 8 bits. On the 8th bit:
    - If bit7=1 and addr < MEM_DEPTH, load the pointer with addr and go to DATA.
    - Otherwise set `frame_err` and go to DROP.
  - DATA: shifts 8 bits. On each 8th bit, register `mem_data`=byte, `mem_addr`=pointer and `mem_we`=1 for one clk. The pointer then becomes pointer+1, or 0 if pointer = MEM_DEPTH-1.
  - DROP: ignores all sclk edges and generates no writes.
- From HDR, DATA or DROP, a cs_n rise (synchronized) returns to IDLE.
  - If the bit counter is nonzero at that point, the partial byte is discarded, no write occurs, and `frame_err` is set.
  - A cs_n rise with zero bits pending is a clean end; `frame_err` is unchanged.
- A cs_n rise and an 8th-bit sclk rise detected in the same clk cycle: the byte completes (write issued), then the block returns to IDLE.
- `mem_data` and `mem_addr` hold their last values between strobes. `mem_we` is never high for two consecutive clks.
- After reset deasserts, the block stays in IDLE until it sees a cs_n fall. A frame already in progress at reset release is ignored entirely.
- `busy` = (state != IDLE).

## Timing
- Reset values: `mem_data`=0, `mem_addr`=0, `mem_we`=0, `busy`=0, `frame_err`=0, `checksum`=0, state=IDLE, all synchronizer flops = idle levels (sclk 0, cs_n 1).
- Latency: `mem_we` is high during the clk cycle that follows the 3rd clk rising edge after the 8th payload-bit sclk rise reaches the pin. `mem_addr`, `mem_data` and `checksum` update on that same edge.
- `busy` rises 3 clk edges after cs_n falls at the pin and falls 3 clk edges after cs_n rises at the pin.
- Host constraints:
  - sclk high time and low time each ≥ 3 clk periods.
  - cs_n setup to the first sclk rise ≥ 3 clk periods.
  - Faster sclk is out of spec; behaviour is then undefined but must never produce more than one `mem_we` per 8 detected sclk rises.

## Configuration
- `LOADER_CHECKSUM_EN` defined: `checksum` accumulates an 8-bit wrap-around sum of every payload byte written in the frame. It updates on the same edge as `mem_we`, is cleared on cs_n fall, and holds after the frame ends.
- Not defined: the accumulator is not built and `checksum` is tied to 8'h00. The port is always present.

## Test plan
- Reset with random inputs toggling: all outputs are 0; no `mem_we` until a cs_n fall is seen after reset release.
- Frame 0x80, 0x11, 0x22, 0x33: three single-clk strobes at (addr, data) = (0,0x11), (1,0x22), (2,0x33). `frame_err`=0. `checksum`=0x66 (0x00 without macro).
- Frame 0xFB, 0xA1, 0xA2, 0xA3, 0xA4: writes at addresses 123, 124, 0, 1 in that order.
- Headers 0x05 (no write bit) and 0xFD (addr 125), each followed by 2 payload bytes: no strobes; `frame_err`=1 after each header.
- Frame 0x80 plus 5 bits, then cs_n high: no write, `frame_err`=1. The next clean frame clears `frame_err` to 0 at its cs_n fall.
- `reset` pulsed after 2 payload bytes, with the frame continuing for 2 more bytes: outputs go to 0 immediately, no further strobes occur, and a subsequent new frame writes normally.
